// File: rtl/bits16_demux_buf.sv
// Per-channel FIFO: DEPTH entries. A pushed beat appears on o_dat one cycle after its push edge.
// The producer must not push when o_full is set; o_full depends only on stored state.
module bits16_demux_buf_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop_rdy,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;

    assign o_vld  = (r_count != '0);
    assign o_full = (r_count == FULL_CNT);
    assign o_dat  = r_mem[r_rd_ptr];
    assign w_pop  = o_vld & i_pop_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// 16-bit 1->2 buffered demux: routes each input beat to channel in_sel's own FIFO.
// Latency: one cycle from accept edge to the beat appearing on outc.
// Backpressure: in_ready drops only while the selected channel's FIFO is full; never passes through out*_ready.
module bits16_demux_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out0_valid,
    output logic [WIDTH-1:0] out0_data,
    input  logic             out0_ready,
    output logic             out1_valid,
    output logic [WIDTH-1:0] out1_data,
    input  logic             out1_ready
);

    logic w_full0;
    logic w_full1;
    logic w_push0;
    logic w_push1;

    assign in_ready = in_sel ? ~w_full1 : ~w_full0;
    assign w_push0  = in_valid & in_ready & ~in_sel;
    assign w_push1  = in_valid & in_ready &  in_sel;

    bits16_demux_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push0),
        .i_push_dat (in_data),
        .i_pop_rdy  (out0_ready),
        .o_vld      (out0_valid),
        .o_dat      (out0_data),
        .o_full     (w_full0)
    );

    bits16_demux_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push1),
        .i_push_dat (in_data),
        .i_pop_rdy  (out1_ready),
        .o_vld      (out1_valid),
        .o_dat      (out1_data),
        .o_full     (w_full1)
    );

endmodule

// File: tb/tb_bits16_demux_buf.sv
// Scoreboard bench for bits16_demux_buf: the driver queues expected beats per channel at accept,
// a monitor compares every popped head against its queue.
module tb_bits16_demux_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_sel;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out0_valid;
    logic [15:0] out0_data;
    logic        out0_ready;
    logic        out1_valid;
    logic [15:0] out1_data;
    logic        out1_ready;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp0_q[$];
    logic [15:0] exp1_q[$];
    bit          stall_en = 1'b0;

    bits16_demux_buf #(.WIDTH(16), .DEPTH(2), .AW(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %h, expected no beat", name, act);
    endtask

    // Drive one beat, wait (bounded) for acceptance, queue it as expected for its channel.
    task automatic send(input logic sel, input logic [15:0] dat);
        bit done = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = dat;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                if (sel) exp1_q.push_back(dat);
                else     exp0_q.push_back(dat);
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    // Monitor: a head presented with ready high at negedge is taken at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (out0_valid && out0_ready) begin
                    if (exp0_q.size() == 0) fail_now("ch0_unexpected_beat", {16'h0, out0_data});
                    else chk("ch0_data", {16'h0, out0_data}, {16'h0, exp0_q.pop_front()});
                end
                if (out1_valid && out1_ready) begin
                    if (exp1_q.size() == 0) fail_now("ch1_unexpected_beat", {16'h0, out1_data});
                    else chk("ch1_data", {16'h0, out1_data}, {16'h0, exp1_q.pop_front()});
                end
            end
        end
    end

    // Random consumer stalls during the wrap-around phase.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_en) begin
                out0_ready = 1'($urandom_range(0, 1));
                out1_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = 16'h0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        #3;
        chk("rst_in_ready",   {31'h0, in_ready},   32'd1);
        chk("rst_out0_valid", {31'h0, out0_valid}, 32'd0);
        chk("rst_out1_valid", {31'h0, out1_valid}, 32'd0);
        chk("rst_out0_data",  {16'h0, out0_data},  32'h0);
        chk("rst_out1_data",  {16'h0, out1_data},  32'h0);
        #20 rst_n = 1'b1;

        // Routing
        send(1'b0, 16'hA5A5);
        chk("route0_valid",      {31'h0, out0_valid}, 32'd1);
        chk("route0_data",       {16'h0, out0_data},  32'h0000_A5A5);
        chk("route0_other_idle", {31'h0, out1_valid}, 32'd0);
        send(1'b1, 16'h5A5A);
        chk("route1_valid",      {31'h0, out1_valid}, 32'd1);
        chk("route1_data",       {16'h0, out1_data},  32'h0000_5A5A);
        chk("route1_other_idle", {31'h0, out0_valid}, 32'd0);
        cycles(3);

        // Full / backpressure on channel 0 only
        out0_ready = 1'b0;
        send(1'b0, 16'h0001);
        send(1'b0, 16'h0002);
        in_sel = 1'b0; #1;
        chk("full_ready_sel0", {31'h0, in_ready}, 32'd0);
        in_sel = 1'b1; #1;
        chk("full_ready_sel1", {31'h0, in_ready}, 32'd1);
        send(1'b1, 16'h0003);
        @(posedge clk); #1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hDEAD;
        cycles(2);
        chk("blocked_ready", {31'h0, in_ready}, 32'd0);
        chk("blocked_hold",  {16'h0, out0_data}, 32'h0000_0001);
        in_valid = 1'b0;
        out0_ready = 1'b1;
        cycles(4);
        chk("full_drained", {31'h0, out0_valid}, 32'd0);

        // Simultaneous push and pop on channel 1
        out1_ready = 1'b0;
        send(1'b1, 16'h1111);
        out1_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h2222;
        @(negedge clk);
        chk("pp_ready", {31'h0, in_ready}, 32'd1);
        if (in_ready) exp1_q.push_back(16'h2222);
        @(posedge clk); #1;
        in_valid = 1'b0; out1_ready = 1'b0;
        chk("pp_valid", {31'h0, out1_valid}, 32'd1);
        chk("pp_data",  {16'h0, out1_data},  32'h0000_2222);
        cycles(1);
        chk("pp_count_not_full", {31'h0, in_ready}, 32'd1);
        out1_ready = 1'b1;
        cycles(1);
        chk("pp_count_was_one", {31'h0, out1_valid}, 32'd0);

        // Dual pop
        out0_ready = 1'b0; out1_ready = 1'b0;
        send(1'b0, 16'h00AA);
        send(1'b1, 16'h00BB);
        send(1'b0, 16'h00CC);
        out0_ready = 1'b1; out1_ready = 1'b1;
        cycles(1);
        chk("dual_out0_valid", {31'h0, out0_valid}, 32'd1);
        chk("dual_out0_data",  {16'h0, out0_data},  32'h0000_00CC);
        chk("dual_out1_valid", {31'h0, out1_valid}, 32'd0);
        cycles(1);
        chk("dual_out0_empty", {31'h0, out0_valid}, 32'd0);

        // Wrap-around with random stalls
        stall_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(1'(i % 2), 16'(i));
        end
        stall_en = 1'b0;
        @(posedge clk); #1;
        out0_ready = 1'b1; out1_ready = 1'b1;
        cycles(6);
        chk("wrap_q0_empty", exp0_q.size(), 32'd0);
        chk("wrap_q1_empty", exp1_q.size(), 32'd0);
        chk("wrap_out_idle", {30'h0, out1_valid, out0_valid}, 32'd0);

        // Asynchronous reset with both FIFOs full
        out0_ready = 1'b0; out1_ready = 1'b0;
        send(1'b0, 16'hC0C0);
        send(1'b0, 16'hC1C1);
        send(1'b1, 16'hD0D0);
        send(1'b1, 16'hD1D1);
        in_sel = 1'b1; #1;
        chk("prerst_full", {31'h0, in_ready}, 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        chk("arst_in_ready",   {31'h0, in_ready},   32'd1);
        chk("arst_out0_valid", {31'h0, out0_valid}, 32'd0);
        chk("arst_out1_valid", {31'h0, out1_valid}, 32'd0);
        chk("arst_out0_data",  {16'h0, out0_data},  32'h0);
        chk("arst_out1_data",  {16'h0, out1_data},  32'h0);
        exp0_q.delete();
        exp1_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out0_ready = 1'b1; out1_ready = 1'b1;
        cycles(3);
        chk("post_rst_idle", {30'h0, out1_valid, out0_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
